// File: rtl/result_stream_if.sv
// Purpose: bundles the control, RAM read port and output byte stream of result_stream_reader.
// Latency: none (wires only).
// Backpressure: out_valid/out_ready handshake on the stream; the RAM port has no backpressure.
// Ports: master = the reader (drives busy/done/mem_addr/mem_rd/out_*/checksum);
//        slave  = host + RAM side (drives start/tile_order/mem_data/out_ready).
interface result_stream_if #(
  parameter int ADDR_W = 19
);
  logic              start;
  logic              tile_order;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [15:0]       checksum;

  modport master (
    input  start, tile_order, mem_data, out_ready,
    output busy, done, mem_addr, mem_rd, out_data, out_valid, out_last, checksum
  );

  modport slave (
    output start, tile_order, mem_data, out_ready,
    input  busy, done, mem_addr, mem_rd, out_data, out_valid, out_last, checksum
  );
endinterface

// File: rtl/result_stream_reader.sv
// Purpose: reads an IMG_W x IMG_H byte image from a sync-read RAM in raster or TILE x TILE
//          tile order and streams it out as bytes with a last flag.
// Latency: first byte valid RD_LAT+2 cycles after start; start-to-done IMG_W*IMG_H+RD_LAT+3 with
//          out_ready held high. Backpressure: reads are issued only while FIFO entries plus reads
//          in flight leave room, so a stalled sink stalls issue and nothing is dropped.
// Ports: clk, rst (async, active-high); bus (result_stream_if.master): start/tile_order in,
//        busy/done out, mem_addr/mem_rd out + mem_data in, out_data/out_valid/out_last out +
//        out_ready in, checksum out.
// Option: define RESULT_READER_CHECKSUM_EN to build the 16-bit running byte sum; otherwise
//         checksum is tied to 0.
module result_stream_reader #(
  parameter int IMG_W      = 400,
  parameter int IMG_H      = 400,
  parameter int TILE       = 10,
  parameter int ADDR_W     = 19,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  result_stream_if.master  bus
);

  localparam int NPIX    = IMG_W * IMG_H;
  localparam int TILES_X = IMG_W / TILE;
  localparam int TW      = $clog2(TILE + 1);
  localparam int TXW     = $clog2(TILES_X + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NPIX - 1);
  // End of a tile row -> start of the next row in the same tile.
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W - TILE + 1);
  localparam logic [ADDR_W-1:0] TILE_STEP = ADDR_W'(TILE);
  // Last tile of a tile row -> first tile of the next tile row.
  localparam logic [ADDR_W-1:0] TROW_STEP = ADDR_W'(TILE * IMG_W - IMG_W + TILE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic              order_q;
  logic [ADDR_W-1:0] pix_cnt, addr_q, tile_base;
  logic [TW-1:0]     c_cnt, r_cnt;
  logic [TXW-1:0]    tx_cnt;
  logic              last_xfer;

  logic [RD_LAT-1:0] pipe_vld, pipe_last;
  logic [CW-1:0]     inflight, fifo_count;
  logic [CW:0]       occ;
  logic [8:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  logic start_acc, issue, issue_last, push, pop, credit_ok;

  assign start_acc  = (state == IDLE) && bus.start;
  assign issue_last = (pix_cnt == LAST_PIX);
  assign push       = pipe_vld[RD_LAT-1];
  assign pop        = bus.out_valid && bus.out_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe_vld[i]);
  end

  // A pop this cycle frees an entry before the new read can land, so it counts as credit.
  assign occ       = {1'b0, fifo_count} + {1'b0, inflight} - (CW+1)'(pop);
  assign credit_ok = occ < (CW+1)'(FIFO_DEPTH);
  assign issue     = (state == RUN) && credit_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (issue && issue_last) state_nx = DRAIN;
      DRAIN:   if (fifo_count == '0 && inflight == '0 && last_xfer) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address generation: running bases and increments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      order_q   <= 1'b0;
      pix_cnt   <= '0;
      addr_q    <= '0;
      tile_base <= '0;
      c_cnt     <= '0;
      r_cnt     <= '0;
      tx_cnt    <= '0;
    end else if (start_acc) begin
      order_q   <= bus.tile_order;
      pix_cnt   <= '0;
      addr_q    <= '0;
      tile_base <= '0;
      c_cnt     <= '0;
      r_cnt     <= '0;
      tx_cnt    <= '0;
    end else if (issue) begin
      pix_cnt <= issue_last ? '0 : pix_cnt + 1'b1;
      if (!order_q) begin
        addr_q <= issue_last ? '0 : addr_q + 1'b1;
      end else if (c_cnt != TW'(TILE - 1)) begin
        c_cnt  <= c_cnt + 1'b1;
        addr_q <= addr_q + 1'b1;
      end else begin
        c_cnt <= '0;
        if (r_cnt != TW'(TILE - 1)) begin
          r_cnt  <= r_cnt + 1'b1;
          addr_q <= addr_q + ROW_STEP;
        end else begin
          r_cnt <= '0;
          if (tx_cnt != TXW'(TILES_X - 1)) begin
            tx_cnt    <= tx_cnt + 1'b1;
            tile_base <= tile_base + TILE_STEP;
            addr_q    <= tile_base + TILE_STEP;
          end else begin
            tx_cnt    <= '0;
            tile_base <= issue_last ? '0 : tile_base + TROW_STEP;
            addr_q    <= issue_last ? '0 : tile_base + TROW_STEP;
          end
        end
      end
    end
  end

  // Read-latency tracker: each issued read carries its last tag until its data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  // Output FIFO of {last, data}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {pipe_last[RD_LAT-1], bus.mem_data};
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       last_xfer <= 1'b0;
    else if (start_acc)            last_xfer <= 1'b0;
    else if (pop && bus.out_last)  last_xfer <= 1'b1;
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd    = issue;
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = fifo_mem[rd_ptr][7:0];
  assign bus.out_last  = bus.out_valid && fifo_mem[rd_ptr][8];

`ifdef RESULT_READER_CHECKSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            csum_q <= '0;
    else if (start_acc) csum_q <= '0;
    else if (pop)       csum_q <= csum_q + {8'd0, bus.out_data};
  end
  assign bus.checksum = csum_q;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_result_stream_reader.sv
// Bench for result_stream_reader on a reduced 40x30 image (4x3 tiles of 10x10), RD_LAT=1.
module tb_result_stream_reader;
  localparam int W = 40, H = 30, T = 10, AW = 19, LAT = 1, DEPTH = 4;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_stream_if #(.ADDR_W(AW)) bus();

  result_stream_reader #(
    .IMG_W(W), .IMG_H(H), .TILE(T), .ADDR_W(AW), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read RAM, latency 1.
  logic [7:0] ram [NPIX];
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      if (bus.mem_addr < AW'(NPIX)) bus.mem_data <= ram[bus.mem_addr];
      else                          bus.mem_data <= 8'h00;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passes = 0;
  int exp_addr[$];
  int iss_log[$];
  int byte_log[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference order straight from the address formulas.
  task automatic build_model(input logic order);
    exp_addr.delete();
    if (!order) begin
      for (int a = 0; a < NPIX; a++) exp_addr.push_back(a);
    end else begin
      for (int ty = 0; ty < H / T; ty++)
        for (int tx = 0; tx < W / T; tx++)
          for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++)
              exp_addr.push_back((ty * T + r) * W + tx * T + c);
    end
  endtask

  task automatic fill_ram(input int mode);
    for (int a = 0; a < NPIX; a++) begin
      if (mode == 0)      ram[a] = 8'(a);
      else if (mode == 1) ram[a] = 8'hFF;
      else                ram[a] = 8'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_mem_addr"},  bus.mem_addr, 0);
    check({tag, "_mem_rd"},    bus.mem_rd, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"},  bus.out_last, 0);
    check({tag, "_checksum"},  bus.checksum, 0);
  endtask

  // Called at posedge+1 with the bench idle. Runs one readback and checks it against the model.
  task automatic run_img(input logic order, input int pct, input int rst_at, input logic pulse);
    int iss, nb, dones, start_cyc, done_cyc, first_cyc, t, bad;
    logic stall, sl;
    logic [7:0] sd;
    logic [15:0] exp_sum, csum;
    build_model(order);
    iss_log.delete();
    byte_log.delete();
    iss = 0; nb = 0; dones = 0; done_cyc = -1; first_cyc = -1; t = 0;
    stall = 1'b0; sl = 1'b0; sd = 8'h00; exp_sum = 16'h0; csum = 16'h0;
    bus.out_ready = ($urandom_range(99) < pct);
    bus.start = 1'b1;
    bus.tile_order = order;
    @(posedge clk); #1;
    bus.start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", bus.busy, 1);
    while (dones == 0 && t < NPIX * 8 + 200) begin
      @(negedge clk);
      if (t == 0) begin
        check("first_rd", bus.mem_rd, 1);
        check("first_addr", bus.mem_addr, 0);
      end
      if (stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, sd);
        check("stall_last", bus.out_last, sl);
      end
      if (bus.mem_rd) begin
        if (iss < NPIX) check("addr_seq", bus.mem_addr, exp_addr[iss]);
        else            check("extra_read", iss, NPIX - 1);
        iss_log.push_back(int'(bus.mem_addr));
        iss++;
      end
      if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (nb < NPIX) begin
          check("byte_data", bus.out_data, ram[exp_addr[nb]]);
          check("byte_last", bus.out_last, (nb == NPIX - 1));
          exp_sum = exp_sum + 16'(ram[exp_addr[nb]]);
        end else begin
          check("extra_byte", nb, NPIX - 1);
        end
        byte_log.push_back(int'(bus.out_data));
        nb++;
      end
      check("credit_bound", ((iss - nb) <= DEPTH), 1);
      stall = bus.out_valid && !bus.out_ready;
      sd = bus.out_data;
      sl = bus.out_last;
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
        csum = bus.checksum;
        check("busy_at_done", bus.busy, 1);
      end
      if (rst_at > 0 && nb >= rst_at) break;
      @(posedge clk); #1;
      t++;
      bus.out_ready = ($urandom_range(99) < pct);
      bus.start = pulse && (t == 50 || t == NPIX / 2 || t == NPIX - 3);
    end
    bus.start = 1'b0;

    if (rst_at > 0) begin
      // Asynchronous reset in the middle of the stream, between clock edges.
      #2; rst = 1'b1; #1;
      check_all_zero("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.out_valid || bus.done || bus.mem_rd || bus.busy) bad++;
      end
      check("quiet_after_rst", bad, 0);
      @(posedge clk); #1;
      return;
    end

    check("done_seen", dones, 1);
    check("byte_count", nb, NPIX);
    check("read_count", iss, NPIX);
    if (pct >= 100) begin
      check("done_latency", done_cyc - start_cyc + 1, NPIX + LAT + 3);
      check("first_byte_latency", first_cyc - start_cyc + 1, LAT + 2);
    end
`ifdef RESULT_READER_CHECKSUM_EN
    check("checksum_done", csum, exp_sum);
`else
    check("checksum_done", csum, 0);
`endif
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done || bus.mem_rd || bus.out_valid || bus.busy) bad++;
    end
    check("idle_after_done", bad, 0);
    check("checksum_hold", bus.checksum, csum);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic order;
    int   pct;
    int   ram_mode;
    int   rst_at;
    logic pulse;
  } run_t;

  typedef struct {
    logic order;
    int   idx;
    int   addr;
  } addr_t;

  run_t  runs[8];
  addr_t atab[10];

  initial begin
    runs[0] = '{order: 1'b0, pct: 100, ram_mode: 0, rst_at: 0,   pulse: 1'b0};
    runs[1] = '{order: 1'b1, pct: 100, ram_mode: 0, rst_at: 0,   pulse: 1'b0};
    runs[2] = '{order: 1'b1, pct: 30,  ram_mode: 2, rst_at: 0,   pulse: 1'b0};
    runs[3] = '{order: 1'b0, pct: 30,  ram_mode: 2, rst_at: 0,   pulse: 1'b0};
    runs[4] = '{order: 1'b0, pct: 100, ram_mode: 2, rst_at: 500, pulse: 1'b0};
    runs[5] = '{order: 1'b0, pct: 100, ram_mode: 0, rst_at: 0,   pulse: 1'b0};
    runs[6] = '{order: 1'b1, pct: 70,  ram_mode: 2, rst_at: 0,   pulse: 1'b1};
    runs[7] = '{order: 1'b0, pct: 100, ram_mode: 1, rst_at: 0,   pulse: 1'b0};

    // Hand-derived stream positions for a 40x30 image with 10x10 tiles.
    atab[0] = '{order: 1'b0, idx: 0,    addr: 0};
    atab[1] = '{order: 1'b0, idx: 41,   addr: 41};
    atab[2] = '{order: 1'b0, idx: 1199, addr: 1199};
    atab[3] = '{order: 1'b1, idx: 9,    addr: 9};
    atab[4] = '{order: 1'b1, idx: 10,   addr: 40};
    atab[5] = '{order: 1'b1, idx: 99,   addr: 369};
    atab[6] = '{order: 1'b1, idx: 100,  addr: 10};
    atab[7] = '{order: 1'b1, idx: 400,  addr: 400};
    atab[8] = '{order: 1'b1, idx: 555,  addr: 615};
    atab[9] = '{order: 1'b1, idx: 1199, addr: 1199};

    bus.start = 1'b0;
    bus.tile_order = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      fill_ram(runs[i].ram_mode);
      run_img(runs[i].order, runs[i].pct, runs[i].rst_at, runs[i].pulse);
      if (runs[i].ram_mode == 0 && runs[i].rst_at == 0) begin
        for (int j = 0; j < 10; j++) begin
          if (atab[j].order == runs[i].order) begin
            if (iss_log.size() > atab[j].idx && byte_log.size() > atab[j].idx) begin
              check("tab_addr", iss_log[atab[j].idx], atab[j].addr);
              check("tab_byte", byte_log[atab[j].idx], atab[j].addr % 256);
            end else begin
              check("tab_short_stream", byte_log.size(), NPIX);
            end
          end
        end
      end
      if (runs[i].ram_mode == 1) begin
`ifdef RESULT_READER_CHECKSUM_EN
        check("checksum_ff", bus.checksum, (NPIX * 255) % 65536);
`else
        check("checksum_ff", bus.checksum, 0);
`endif
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
